// File: rtl/tdm_demux_16.sv
// tdm_demux_16: receive-side TDM demultiplexer, slot-serial beats to an atomically published 16-channel frame.
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          block enable; low freezes all state (pulses still clear)
//   din         DW-bit slot beat
//   din_valid   beat present on din this cycle
//   sync        frame start, qualified by din_valid; marks the beat as slot 0
//   W           published frame, channel i at W[i*DW +: DW]
//   frame_valid one-cycle pulse when W updates
//   slot        index of the next expected slot
//   locked      high while in RUN
//   err         one-cycle pulse on a framing error
//   perr        one-cycle pulse on a parity failure (tied 0 without the parity option)
// Optional feature: define TDM_DEMUX_PARITY_EN for a 17-slot frame whose last
// slot carries even parity (XOR of slots 0..15) that gates publication.
module tdm_demux_16 #(
    parameter int DW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DW-1:0]     din,
    input  logic              din_valid,
    input  logic              sync,
    output logic [16*DW-1:0]  W,
    output logic              frame_valid,
    output logic [4:0]        slot,
    output logic              locked,
    output logic              err,
    output logic              perr
);
    localparam logic HUNT = 1'b0;
    localparam logic RUN  = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
    // All 16 channels are buffered; the parity beat only gates publication.
    localparam int         NSH  = 16;
    localparam logic [4:0] LAST = 5'd16;
`else
    // Slot 15 goes straight into W, so only channels 0..14 need buffering.
    localparam int         NSH  = 15;
    localparam logic [4:0] LAST = 5'd15;
`endif
    logic              state;
    logic [NSH*DW-1:0] shadow;
    logic              beat;
    assign beat   = en & din_valid;
    assign locked = (state == RUN);
`ifdef TDM_DEMUX_PARITY_EN
    logic [DW-1:0] par;
    always_comb begin
        par = '0;
        for (int i = 0; i < 16; i++) par ^= shadow[i*DW +: DW];
    end
`else
    assign perr = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            W           <= '0;
            shadow      <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            perr        <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            err         <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            perr        <= 1'b0;
`endif
            if (beat) begin
                if (state == HUNT) begin
                    if (sync) begin
                        shadow[DW-1:0] <= din;
                        slot           <= 5'd1;
                        state          <= RUN;
                    end
                end else if (sync) begin
                    // A sync anywhere but slot 0 is a short frame; the partial frame is dropped.
                    err            <= (slot != 5'd0);
                    shadow[DW-1:0] <= din;
                    slot           <= 5'd1;
                end else if (slot == 5'd0) begin
                    err   <= 1'b1;
                    state <= HUNT;
                end else if (slot == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                    if (din == par) begin
                        W           <= shadow;
                        frame_valid <= 1'b1;
                    end else begin
                        perr <= 1'b1;
                    end
`else
                    W           <= {din, shadow};
                    frame_valid <= 1'b1;
`endif
                    slot <= 5'd0;
                end else begin
                    shadow[slot*DW +: DW] <= din;
                    slot                  <= slot + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_16.sv
// tb_tdm_demux_16: table, directed and randomized checks of tdm_demux_16 against a queue-based frame model.
module tb_tdm_demux_16;
    localparam int DW = 1;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int N = 17;
`else
    localparam int N = 16;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic din_valid = 1'b0;
    logic sync = 1'b0;
    logic [DW-1:0] din = '0;
    logic [16*DW-1:0] w;
    logic frame_valid, locked, err, perr;
    logic [4:0] slot;

    tdm_demux_16 #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid), .sync(sync),
        .W(w), .frame_valid(frame_valid), .slot(slot), .locked(locked), .err(err), .perr(perr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    bit bad_par = 0;

    // Reference model: collected beats of the current frame live in a queue.
    bit               m_locked;
    int               m_q[$];
    logic [16*DW-1:0] m_w;
    bit               m_fv, m_err, m_perr;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_q.delete();
        m_w = '0;
        m_fv = 0;
        m_err = 0;
        m_perr = 0;
    endtask

    task automatic model_publish();
        logic [16*DW-1:0] f;
        int p;
        f = '0;
        p = 0;
        for (int i = 0; i < 16; i++) begin
            f |= (16*DW)'(m_q[i]) << (i*DW);
            p ^= m_q[i];
        end
        if (N == 16 || p == m_q[16]) begin
            m_w = f;
            m_fv = 1;
        end else begin
            m_perr = 1;
        end
    endtask

    task automatic model_step(bit e, bit v, bit s, logic [DW-1:0] d);
        m_fv = 0;
        m_err = 0;
        m_perr = 0;
        if (e && v) begin
            if (!m_locked) begin
                if (s) begin
                    m_q = '{int'(d)};
                    m_locked = 1;
                end
            end else if (s) begin
                m_err = (m_q.size() != 0);
                m_q = '{int'(d)};
            end else if (m_q.size() == 0) begin
                m_err = 1;
                m_locked = 0;
            end else begin
                m_q.push_back(int'(d));
                if (m_q.size() == N) begin
                    model_publish();
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ".W"}, w, m_w);
        chk({tag, ".frame_valid"}, frame_valid, m_fv);
        chk({tag, ".slot"}, slot, m_q.size());
        chk({tag, ".locked"}, locked, m_locked);
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".perr"}, perr, m_perr);
    endtask

    task automatic step(string tag, bit e, bit v, bit s, logic [DW-1:0] d, bit check = 1);
        en = e;
        din_valid = v;
        sync = s;
        din = d;
        @(posedge clk);
        #1;
        model_step(e, v, s, d);
        if (frame_valid) fv_count++;
        if (check) compare_all(tag);
    endtask

    function automatic logic [DW-1:0] beat_of(logic [15:0] data, int i);
        logic [DW-1:0] p;
        p = '0;
        if (i < 16) return data[i*DW +: DW];
        for (int k = 0; k < 16; k++) p ^= data[k*DW +: DW];
        return p ^ DW'(bad_par);
    endfunction

    // Beats from..to of one frame; slot 0 carries sync, random gaps optional.
    task automatic send_beats(string tag, logic [15:0] data, int from, int to, bit gaps);
        for (int i = from; i <= to; i++) begin
            if (gaps && ($urandom % 3 == 0)) step({tag, ".gap"}, 1, 0, 0, DW'($urandom));
            step(tag, 1, 1, i == 0, beat_of(data, i));
        end
    endtask

    task automatic reset_dut();
        rst_n = 0;
        #2;
        chk("rst.W", w, 0);
        chk("rst.slot", slot, 0);
        chk("rst.locked", locked, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        bit e, v, s;
        logic [DW-1:0] d;
        logic [15:0] w;
        bit fv, er, lk;
        logic [4:0] sl;
    } vec_t;
    vec_t tv[$];

    int g;

    initial begin
        for (int i = 0; i < N; i++)
            tv.push_back('{1'b1, 1'b1, i == 0, (i < 16) ? DW'(i & 1) : DW'(0),
                          (i == N-1) ? 16'hAAAA : 16'h0000, i == N-1, 1'b0, 1'b1,
                          (i == N-1) ? 5'd0 : 5'(i + 1)});
        tv.push_back('{1'b1, 1'b1, 1'b0, DW'(1), 16'hAAAA, 1'b0, 1'b1, 1'b0, 5'd0});
        tv.push_back('{1'b1, 1'b1, 1'b0, DW'(1), 16'hAAAA, 1'b0, 1'b0, 1'b0, 5'd0});
        tv.push_back('{1'b0, 1'b1, 1'b1, DW'(1), 16'hAAAA, 1'b0, 1'b0, 1'b0, 5'd0});
        tv.push_back('{1'b1, 1'b0, 1'b1, DW'(1), 16'hAAAA, 1'b0, 1'b0, 1'b0, 5'd0});
        tv.push_back('{1'b1, 1'b1, 1'b1, DW'(1), 16'hAAAA, 1'b0, 1'b0, 1'b1, 5'd1});

        reset_dut();
        compare_all("idle");
        foreach (tv[i]) begin
            step("tbl", tv[i].e, tv[i].v, tv[i].s, tv[i].d, 0);
            chk($sformatf("tbl%0d.W", i), w, tv[i].w);
            chk($sformatf("tbl%0d.frame_valid", i), frame_valid, tv[i].fv);
            chk($sformatf("tbl%0d.err", i), err, tv[i].er);
            chk($sformatf("tbl%0d.locked", i), locked, tv[i].lk);
            chk($sformatf("tbl%0d.slot", i), slot, tv[i].sl);
            chk($sformatf("tbl%0d.perr", i), perr, 0);
        end

        reset_dut();
        fv_count = 0;
        send_beats("b2b1", 16'h1234, 0, N-1, 1);
        chk("b2b.first", w, 16'h1234);
        step("b2b.hold", 1, 0, 0, DW'(1));
        chk("b2b.stable", w, 16'h1234);
        send_beats("b2b2", 16'hFFFF, 0, N-1, 1);
        chk("b2b.second", w, 16'hFFFF);
        chk("b2b.pulses", fv_count, 2);

        send_beats("short", 16'h00FF, 0, 6, 0);
        send_beats("short.sync", 16'h5A5A, 0, 0, 0);
        chk("short.err", err, 1);
        chk("short.W", w, 16'hFFFF);
        send_beats("short.rest", 16'h5A5A, 1, N-1, 0);
        chk("short.final", w, 16'h5A5A);

        step("loss", 1, 1, 0, DW'(0));
        chk("loss.err", err, 1);
        chk("loss.locked", locked, 0);
        repeat (4) step("loss.ign", 1, 1, 0, DW'($urandom));
        chk("loss.still", locked, 0);
        send_beats("relock", 16'h3C96, 0, N-1, 0);
        chk("relock.W", w, 16'h3C96);

        send_beats("en", 16'hC3C3, 0, 4, 0);
        repeat (5) step("en.off", 0, 1, 1'($urandom), DW'($urandom));
        chk("en.slot", slot, 5);
        send_beats("en.rest", 16'hC3C3, 5, N-1, 0);
        chk("en.W", w, 16'hC3C3);

        send_beats("rst9", 16'h0F0F, 0, 8, 0);
        chk("rst9.slot", slot, 9);
        #2;
        rst_n = 0;
        #1;
        chk("rst9.W", w, 0);
        chk("rst9.slot0", slot, 0);
        chk("rst9.locked", locked, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        compare_all("rst9.after");

`ifdef TDM_DEMUX_PARITY_EN
        bad_par = 0;
        send_beats("par.ok", 16'h0001, 0, N-1, 0);
        chk("par.ok.W", w, 16'h0001);
        chk("par.ok.fv", frame_valid, 1);
        bad_par = 1;
        send_beats("par.bad", 16'h0001, 0, N-1, 0);
        chk("par.bad.perr", perr, 1);
        chk("par.bad.fv", frame_valid, 0);
        chk("par.bad.W", w, 16'h0001);
        bad_par = 0;
`endif

        g = 0;
        for (int n = 0; n < 4000; n++) begin
            bit e, v, s;
            e = ($urandom % 8) != 0;
            v = ($urandom % 4) != 0;
            s = (g == 0) ^ (($urandom % 40) == 0);
            step("rnd", e, v, s, DW'($urandom));
            if (e && v) g = (g + 1) % N;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
